// File: rtl/fwd_hazard_unit_pkg.sv
// Shared forwarding types: select encodings for the EX operand mux3x1s and per-stage tag layouts.
package fwd_hazard_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } stage_tag_t;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rs1;
    logic [REG_ADDR_W_DEF-1:0] rs2;
    logic                      rs1_used;
    logic                      rs2_used;
  } ex_src_t;

  // True when the staged instruction will write register src.
  function automatic logic fwd_hit(input stage_tag_t t, input logic [REG_ADDR_W_DEF-1:0] src);
    return t.valid && t.regwrite && (t.rd == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and forwarding/stall response bundle between the pipeline and fwd_hazard_unit.
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  hold;
  logic                  flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall;
  logic                  bubble;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_regwrite, id_memread, hold, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_regwrite, id_memread, hold, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Operand select for one EX source: MEM result beats WB value, x0 and unread sources use the register file.
module fwd_sel_logic
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  stage_tag_t            mem_tag,
  input  stage_tag_t            wb_tag,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_valid && src_used && (src != '0)) begin
      if (fwd_hit(mem_tag, src)) begin
        sel = FWD_MEM;
      end else if (fwd_hit(wb_tag, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow EX/MEM/WB tag pipeline driving operand forward selects (registered, 0 comb from ID) and
// a same-cycle load-use stall/bubble; hold freezes every tag, flush kills the instruction entering EX.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
);

  stage_tag_t ex_q;
  stage_tag_t mem_q;
  stage_tag_t wb_q;
  ex_src_t    ex_src_q;
  stage_tag_t id_tag;
  ex_src_t    id_src;
  logic       load_use;
  logic       insert_bubble;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = bus.id_valid;
    id_tag.rd       = bus.id_rd;
    id_tag.regwrite = bus.id_regwrite;
    id_tag.memread  = bus.id_memread;

    id_src          = '0;
    id_src.rs1      = bus.id_rs1;
    id_src.rs2      = bus.id_rs2;
    id_src.rs1_used = bus.id_rs1_used;
    id_src.rs2_used = bus.id_rs2_used;
  end

  // A load in EX only has its data after MEM, so a reader directly behind it must wait one cycle.
  always_comb begin
    load_use = 1'b0;
    if (bus.id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0)) begin
      load_use = (bus.id_rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                 (bus.id_rs2_used && (bus.id_rs2 == ex_q.rd));
    end
  end

  assign insert_bubble = load_use && !bus.flush && !bus.hold;
  assign bus.stall     = insert_bubble;
  assign bus.bubble    = insert_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_src_q <= '0;
    end else if (!bus.hold) begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= (insert_bubble || bus.flush) ? '0 : id_tag;
      ex_src_q <= id_src;
    end
  end

  fwd_sel_logic #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sel_a (
    .ex_valid (ex_q.valid),
    .src      (ex_src_q.rs1),
    .src_used (ex_src_q.rs1_used),
    .mem_tag  (mem_q),
    .wb_tag   (wb_q),
    .sel      (bus.fwd_a_sel)
  );

  fwd_sel_logic #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sel_b (
    .ex_valid (ex_q.valid),
    .src      (ex_src_q.rs2),
    .src_used (ex_src_q.rs2_used),
    .mem_tag  (mem_q),
    .wb_tag   (wb_q),
    .sel      (bus.fwd_b_sel)
  );

endmodule
